pcap_stream_arbiter: RTL
========================

# pcap_stream_arbiter

Packet-level round-robin arbiter merging NUM_PORTS 64-bit pcap replay streams onto one 64-bit stream toward the DUT. Once a port's packet is granted, the arbiter holds the grant until that packet's eop beat is accepted, so packets are never interleaved. It sits between the pcap replay sources and the network ingress of the device under test. It provides global pause, optional minimum inter-packet gap enforcement, and a forwarded-packet counter.

## Interface
- NUM_PORTS, 2, number of requesting streams (2..8)
- MIN_IFG, 6, extra idle cycles inserted after each packet (used only with gap feature; 0..255)
- PKT_CNT_W, 8, width of pkt_count
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_data  in  NUM_PORTS*64  per-port beat; port i at [i*64+:64], byte 0 in bits [7:0]
- s_strb  in  NUM_PORTS*8  per-port byte enables
- s_valid  in  NUM_PORTS  per-port beat valid
- s_sop  in  NUM_PORTS  per-port start of packet
- s_eop  in  NUM_PORTS  per-port end of packet
- s_ready  out  NUM_PORTS  per-port accept
- m_data  out  64  merged beat
- m_strb  out  8  merged byte enables
- m_valid  out  1  merged valid
- m_sop  out  1  merged start of packet
- m_eop  out  1  merged end of packet
- m_ready  in  1  downstream accept
- pause  in  1  blocks new grants; an in-flight packet always completes
- grant_port  out  $clog2(NUM_PORTS)  currently or last granted port
- busy  out  1  high in XFER state
- pkt_count  out  PKT_CNT_W  packets forwarded on m_*, wraps modulo 2^PKT_CNT_W

## Operation
- Each s_* bundle is valid/ready: a beat transfers when s_valid[i] & s_ready[i].
- m_* is a single output register. It loads when it is empty or m_ready=1 (`load = ~m_valid | m_ready`).
- s_ready[i] = (state==XFER) & (i==grant_port) & load. All other s_ready bits are 0.
- Request i = s_valid[i]. s_sop is forwarded as presented and is not checked.
- FSM states: IDLE, XFER, GAP (GAP exists only with the gap feature).
- IDLE, when ~pause and any request is present:
  - pick the first requesting port after last_grant, in round-robin order;
  - load grant_port with it;
  - move to XFER.
- IDLE with pause=1 or no request: stay in IDLE.
- XFER: forward beats from the granted port. When a beat with s_eop=1 is accepted:
  - last_grant <= grant_port;
  - move to GAP with gap_cnt=MIN_IFG if the feature is enabled and MIN_IFG>0;
  - otherwise move to IDLE.
- GAP: gap_cnt decrements every cycle. The FSM moves to IDLE on the cycle gap_cnt==1.
- Output register when load=1:
  - it takes the granted beat if one is accepted;
  - otherwise m_valid <= 0.
- pkt_count increments on m_valid & m_ready & m_eop.
- pause asserted mid-packet has no effect on that packet. It only blocks the arbitration step in IDLE.
- If the granted port drops s_valid mid-packet, the grant is held and m_valid bubbles until the port resumes.

## Timing
- Reset values:
  - state=IDLE, last_grant=NUM_PORTS-1 (port 0 wins first), grant_port=0;
  - m_valid=0, m_sop=0, m_eop=0, m_data=0, m_strb=0;
  - pkt_count=0, busy=0, s_ready=0.
- Reset mid-packet abandons the packet: outputs clear at the next edge and no partial beat is retained.
- Latency:
  - 1 cycle from request in IDLE to the grant being registered;
  - 1 more cycle before the first s_ready;
  - 1 cycle from beat acceptance to m_valid.
- With m_ready held high, the output carries back-to-back beats within a packet.
- Between packets on m_valid (m_ready high, next request waiting):
  - 1 idle cycle without the gap feature;
  - MIN_IFG+1 idle cycles with it.
- Simultaneous requests: only one port is granted per arbitration. The others wait, and each requesting port is served within NUM_PORTS packets.
- A request arriving in the same cycle as an eop acceptance is considered at the next IDLE.
- Backpressure: while m_valid & ~m_ready, m_* holds stable and s_ready=0.

## Configuration
- Macro PCAP_ARB_IFG_EN.
- Defined: GAP state and an 8-bit gap_cnt are compiled in, and MIN_IFG is honoured.
- Undefined: no GAP state, no gap_cnt register; XFER goes straight to IDLE after eop and MIN_IFG is ignored.

## Structure
- Package pcap_arb_pkg holds:
  - the FSM state enum (IDLE, XFER, GAP);
  - BEAT_W=64 and STRB_W=8;
  - MAX_PORTS=8.
- Sub-module pcap_rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_PORTS] and last[$clog2(NUM_PORTS)].
  - Outputs: pick index and any.

## Test plan
- Port 0 only, 3-beat packet of 20 bytes, m_ready=1 -> m_sop on beat 1, m_strb ff,ff,0f, m_eop on beat 3, pkt_count=1.
- Ports 0 and 1 each hold 2 queued packets, all requesting from reset -> grant order 0,1,0,1 with no interleaved beats; pkt_count=4.
- Gap feature on, MIN_IFG=6, two back-to-back packets on port 1 -> exactly 7 idle m_valid cycles between m_eop and the next m_sop; 1 idle cycle with the macro off.
- m_ready low for 5 cycles mid-packet -> m_data stable, s_ready=0 throughout, no beat lost or duplicated.
- pause raised during beat 2 of a 4-beat packet with port 2 also requesting -> packet completes, no new grant while paused; port 2 is granted 2 cycles after pause drops.
- rst for 1 cycle mid-packet -> m_valid=0 and pkt_count=0 at the next edge; after release, port 0 is granted first.

Source files
------------

// File: rtl/pcap_arb_pkg.sv
// Shared types and constants for the pcap stream arbiter.
package pcap_arb_pkg;

    localparam int unsigned BEAT_W    = 64;
    localparam int unsigned STRB_W    = 8;
    localparam int unsigned MAX_PORTS = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StGap  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/pcap_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_last, wrapping.
module pcap_rr_pick #(
    parameter int unsigned NUM_PORTS = 2,
    localparam int unsigned IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last,
    output logic [IDX_W-1:0]     o_pick,
    output logic                 o_any
);

    logic              w_found;
    int unsigned       w_idx;
    logic [IDX_W-1:0]  w_idx_t;

    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        w_idx_t = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            w_idx   = (32'(i_last) + k) % NUM_PORTS;
            w_idx_t = IDX_W'(w_idx);
            if (!w_found && i_req[w_idx_t]) begin
                o_pick  = w_idx_t;
                w_found = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/pcap_stream_arbiter.sv
// Packet-level round-robin merge of NUM_PORTS pcap streams onto one registered output.
// Define PCAP_ARB_IFG_EN to compile in the GAP state that enforces MIN_IFG idle cycles.
module pcap_stream_arbiter
    import pcap_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned MIN_IFG   = 6,
    parameter int unsigned PKT_CNT_W = 8,
    localparam int unsigned IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*BEAT_W-1:0] s_data,
    input  logic [NUM_PORTS*STRB_W-1:0] s_strb,
    input  logic [NUM_PORTS-1:0]        s_valid,
    input  logic [NUM_PORTS-1:0]        s_sop,
    input  logic [NUM_PORTS-1:0]        s_eop,
    output logic [NUM_PORTS-1:0]        s_ready,
    output logic [BEAT_W-1:0]           m_data,
    output logic [STRB_W-1:0]           m_strb,
    output logic                        m_valid,
    output logic                        m_sop,
    output logic                        m_eop,
    input  logic                        m_ready,
    input  logic                        pause,
    output logic [IDX_W-1:0]            grant_port,
    output logic                        busy,
    output logic [PKT_CNT_W-1:0]        pkt_count
);

`ifdef PCAP_ARB_IFG_EN
    localparam bit GapEn = 1'b1;
`else
    localparam bit GapEn = 1'b0;
`endif
    // Last grant resets to the top port so port 0 wins the first arbitration.
    localparam logic [IDX_W-1:0] LastRst = IDX_W'(NUM_PORTS - 1);

    arb_state_e         r_state, w_state_d;
    logic [IDX_W-1:0]   r_grant, w_grant_d;
    logic [IDX_W-1:0]   r_last, w_last_d;
    logic [IDX_W-1:0]   w_pick;
    logic               w_any, w_load, w_xfer, w_accept, w_eop_acc;
    logic [BEAT_W-1:0]  r_m_data;
    logic [STRB_W-1:0]  r_m_strb;
    logic               r_m_valid, r_m_sop, r_m_eop;
    logic [PKT_CNT_W-1:0] r_pkt_count;
`ifdef PCAP_ARB_IFG_EN
    logic [7:0]         r_gap_cnt, w_gap_cnt_d;
`endif

    pcap_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .i_req  (s_valid),
        .i_last (r_last),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    assign w_load    = ~r_m_valid | m_ready;
    assign w_xfer    = (r_state == StXfer);
    assign w_accept  = w_xfer & w_load & s_valid[r_grant];
    assign w_eop_acc = w_accept & s_eop[r_grant];

    always_comb begin
        s_ready = '0;
        if (w_xfer && w_load) begin
            s_ready[r_grant] = 1'b1;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
        w_last_d  = r_last;
`ifdef PCAP_ARB_IFG_EN
        w_gap_cnt_d = r_gap_cnt;
`endif
        case (r_state)
            StIdle: begin
                if (!pause && w_any) begin
                    w_grant_d = w_pick;
                    w_state_d = StXfer;
                end
            end
            StXfer: begin
                if (w_eop_acc) begin
                    w_last_d = r_grant;
                    if (GapEn && (MIN_IFG != 0)) begin
                        w_state_d = StGap;
                    end else begin
                        w_state_d = StIdle;
                    end
`ifdef PCAP_ARB_IFG_EN
                    w_gap_cnt_d = 8'(MIN_IFG);
`endif
                end
            end
`ifdef PCAP_ARB_IFG_EN
            StGap: begin
                w_gap_cnt_d = r_gap_cnt - 8'd1;
                if (r_gap_cnt == 8'd1) begin
                    w_state_d = StIdle;
                end
            end
`endif
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_last  <= LastRst;
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
            r_last  <= w_last_d;
        end
    end

`ifdef PCAP_ARB_IFG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= w_gap_cnt_d;
        end
    end
`endif

    // Output stage: a bubble is written whenever the register frees up without a new beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_sop   <= 1'b0;
            r_m_eop   <= 1'b0;
            r_m_data  <= '0;
            r_m_strb  <= '0;
        end else if (w_load) begin
            r_m_valid <= w_accept;
            if (w_accept) begin
                r_m_data <= s_data[r_grant*BEAT_W +: BEAT_W];
                r_m_strb <= s_strb[r_grant*STRB_W +: STRB_W];
                r_m_sop  <= s_sop[r_grant];
                r_m_eop  <= s_eop[r_grant];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_count <= '0;
        end else if (r_m_valid && m_ready && r_m_eop) begin
            r_pkt_count <= r_pkt_count + 1'b1;
        end
    end

    assign m_data     = r_m_data;
    assign m_strb     = r_m_strb;
    assign m_valid    = r_m_valid;
    assign m_sop      = r_m_sop;
    assign m_eop      = r_m_eop;
    assign grant_port = r_grant;
    assign busy       = w_xfer;
    assign pkt_count  = r_pkt_count;

endmodule
